// File: rtl/rtcl_p3s7_hs_dphy_line_parser.sv
// PYTHON300 D-PHY HS burst line parser.
// Splits HS bursts into black-reference and image line packets. Each packet
// leaves as a pixel stream with its own buffer. The parser also reports the
// burst header, a frame counter and sticky error flags.

// Per-stream buffer: the registered output slot counts as the head entry of
// the FIFO, so the total occupancy never exceeds 2**PTR_BITS beats. An empty
// buffer forwards the incoming beat straight into the output register.
module rtcl_p3s7_hs_dphy_line_parser_stream #(
    parameter int DATA_BITS = 10,
    parameter int PTR_BITS  = 6
) (
    input  logic                 i_aclk,
    input  logic                 i_aresetn,
    input  logic                 i_aclken,
    input  logic                 i_wr_valid,
    input  logic [DATA_BITS-1:0] i_wr_data,
    input  logic                 i_wr_user,
    input  logic                 i_wr_last,
    output logic [DATA_BITS-1:0] o_tdata,
    output logic                 o_tuser,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic                 o_overflow
);
    localparam int DEPTH = 2**PTR_BITS;
    localparam int W     = DATA_BITS + 2;

    logic [W-1:0]        r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [PTR_BITS:0]   r_count;
    logic [W-1:0]        r_out;
    logic                r_out_valid;

    logic              w_pop;
    logic [PTR_BITS:0] w_total;
    logic              w_full;
    logic              w_accept;
    logic              w_load;
    logic              w_fifo_rd;
    logic              w_bypass;
    logic              w_fifo_wr;
    logic [W-1:0]      w_wr_word;

    assign w_wr_word  = {i_wr_user, i_wr_last, i_wr_data};
    assign w_pop      = r_out_valid && i_tready;
    assign w_total    = r_count + (PTR_BITS+1)'(r_out_valid);
    assign w_full     = (w_total == (PTR_BITS+1)'(DEPTH));
    // A beat arriving while full is still taken if a beat leaves this cycle.
    assign w_accept   = i_wr_valid && (!w_full || w_pop);
    assign o_overflow = i_wr_valid && w_full && !w_pop;
    assign w_load     = !r_out_valid || w_pop;
    assign w_fifo_rd  = w_load && (r_count != '0);
    assign w_bypass   = w_load && (r_count == '0) && w_accept;
    assign w_fifo_wr  = w_accept && !w_bypass;

    // Storage array write port (no reset needed on the data itself).
    always_ff @(posedge i_aclk) begin
        if (i_aclken && w_fifo_wr) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    // Pointers, occupancy and the registered output slot.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (i_aclken) begin
            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            r_count <= r_count + (PTR_BITS+1)'(w_fifo_wr) - (PTR_BITS+1)'(w_fifo_rd);
            if (w_load) begin
                if (w_fifo_rd) begin
                    r_out       <= r_mem[r_rd_ptr];
                    r_out_valid <= 1'b1;
                end else if (w_bypass) begin
                    r_out       <= w_wr_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign o_tuser  = r_out[W-1];
    assign o_tlast  = r_out[W-2];
    assign o_tdata  = r_out[DATA_BITS-1:0];
    assign o_tvalid = r_out_valid;
endmodule

module rtcl_p3s7_hs_dphy_line_parser #(
    parameter int X_BITS         = 10,
    parameter int Y_BITS         = 10,
    parameter int RAW_BITS       = 10,
    parameter int DPHY_LANES     = 2,
    parameter int CHANNELS       = DPHY_LANES / 2,
    parameter int FIFO_PTR_BITS  = 6,
    parameter int FRAME_CNT_BITS = 16
) (
    input  logic                         i_aresetn,
    input  logic                         i_aclk,
    input  logic                         i_aclken,
    input  logic [X_BITS-1:0]            i_param_black_width,
    input  logic [Y_BITS-1:0]            i_param_black_height,
    input  logic [X_BITS-1:0]            i_param_image_width,
    input  logic [Y_BITS-1:0]            i_param_image_height,
    input  logic [DPHY_LANES*8-1:0]      i_dphy_data,
    input  logic                         i_dphy_valid,
    output logic [CHANNELS*RAW_BITS-1:0] o_black_tdata,
    output logic                         o_black_tuser,
    output logic                         o_black_tlast,
    output logic                         o_black_tvalid,
    input  logic                         i_black_tready,
    output logic [CHANNELS*RAW_BITS-1:0] o_image_tdata,
    output logic                         o_image_tuser,
    output logic                         o_image_tlast,
    output logic                         o_image_tvalid,
    input  logic                         i_image_tready,
    output logic [DPHY_LANES*8-1:0]      o_header_data,
    output logic                         o_header_valid,
    output logic [FRAME_CNT_BITS-1:0]    o_frame_count,
    input  logic                         i_clear_err,
    output logic                         o_err_short,
    output logic                         o_err_overflow
);
    localparam int PIX_BITS = CHANNELS * RAW_BITS;

    generate
        if ((CHANNELS != DPHY_LANES / 2) || (DPHY_LANES < 2) || (DPHY_LANES % 2 != 0)) begin : g_bad_cfg
            $error("CHANNELS must equal DPHY_LANES/2 with an even DPHY_LANES >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_BLACK, ST_IMAGE, ST_SKIP} state_t;

    state_t                      r_state;
    logic [X_BITS-1:0]           r_x;
    logic [X_BITS-1:0]           r_width;
    logic [Y_BITS-1:0]           r_y_black;
    logic [Y_BITS-1:0]           r_y_image;
    logic [FRAME_CNT_BITS-1:0]   r_frame_count;
    logic [DPHY_LANES*8-1:0]     r_header_data;
    logic                        r_header_valid;
    logic                        r_blk_wr_valid;
    logic                        r_img_wr_valid;
    logic [PIX_BITS-1:0]         r_wr_data;
    logic                        r_wr_user;
    logic                        r_wr_last;
    logic                        r_err_short;
    logic                        r_err_overflow;

    logic                        w_fs;
    logic                        w_blk;
    logic [Y_BITS-1:0]           w_y_black_eff;
    logic [Y_BITS-1:0]           w_y_image_eff;
    logic                        w_in_line;
    logic                        w_last;
    logic                        w_user;
    logic                        w_short;
    logic [PIX_BITS-1:0]         w_pixels;
    logic                        w_ovf_blk;
    logic                        w_ovf_img;

    // Header fields; a frame start rewinds both line counters before routing.
    assign w_fs          = i_dphy_data[0];
    assign w_blk         = i_dphy_data[1];
    assign w_y_black_eff = w_fs ? '0 : r_y_black;
    assign w_y_image_eff = w_fs ? '0 : r_y_image;

    assign w_in_line = (r_state == ST_BLACK) || (r_state == ST_IMAGE);
    assign w_last    = (r_x == r_width - X_BITS'(CHANNELS));
    assign w_user    = (r_x == '0) &&
                       ((r_state == ST_BLACK) ? (r_y_black == '0) : (r_y_image == '0));
    assign w_short   = w_in_line && !i_dphy_valid;

    // Each 16-bit little-endian lane pair carries one pixel; upper bits dropped.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign w_pixels[gi*RAW_BITS +: RAW_BITS] = i_dphy_data[gi*16 +: RAW_BITS];
        end
    endgenerate

    // Burst FSM: header decode, line position tracking and frame counting.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state        <= ST_IDLE;
            r_x            <= '0;
            r_width        <= '0;
            r_y_black      <= '0;
            r_y_image      <= '0;
            r_frame_count  <= '0;
            r_header_data  <= '0;
            r_header_valid <= 1'b0;
        end else if (i_aclken) begin
            r_header_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_dphy_valid) begin
                        r_header_data  <= i_dphy_data;
                        r_header_valid <= 1'b1;
                        r_x            <= '0;
                        if (w_fs) begin
                            r_y_black     <= '0;
                            r_y_image     <= '0;
                            r_frame_count <= r_frame_count + FRAME_CNT_BITS'(1);
                        end
                        r_width <= w_blk ? i_param_black_width : i_param_image_width;
                        if (w_blk && (w_y_black_eff < i_param_black_height)) begin
                            r_state <= ST_BLACK;
                        end else if (!w_blk && (w_y_image_eff < i_param_image_height)) begin
                            r_state <= ST_IMAGE;
                        end else begin
                            r_state <= ST_SKIP;
                        end
                    end
                end
                ST_BLACK, ST_IMAGE: begin
                    if (!i_dphy_valid) begin
                        r_x     <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_x     <= '0;
                        r_state <= ST_SKIP;
                        if (r_state == ST_BLACK) r_y_black <= r_y_black + Y_BITS'(1);
                        else                     r_y_image <= r_y_image + Y_BITS'(1);
                    end else begin
                        r_x <= r_x + X_BITS'(CHANNELS);
                    end
                end
                ST_SKIP: begin
                    if (!i_dphy_valid) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Unpack stage: one registered beat shared by both streams, per-stream valid.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_blk_wr_valid <= 1'b0;
            r_img_wr_valid <= 1'b0;
            r_wr_data      <= '0;
            r_wr_user      <= 1'b0;
            r_wr_last      <= 1'b0;
        end else if (i_aclken) begin
            r_blk_wr_valid <= i_dphy_valid && (r_state == ST_BLACK);
            r_img_wr_valid <= i_dphy_valid && (r_state == ST_IMAGE);
            r_wr_data      <= w_pixels;
            r_wr_user      <= w_user;
            r_wr_last      <= w_last;
        end
    end

    // Sticky error flags; a clear wins over a simultaneous new error.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_err_short    <= 1'b0;
            r_err_overflow <= 1'b0;
        end else if (i_aclken) begin
            if (i_clear_err) begin
                r_err_short    <= 1'b0;
                r_err_overflow <= 1'b0;
            end else begin
                if (w_short)               r_err_short    <= 1'b1;
                if (w_ovf_blk || w_ovf_img) r_err_overflow <= 1'b1;
            end
        end
    end

    rtcl_p3s7_hs_dphy_line_parser_stream #(
        .DATA_BITS (PIX_BITS),
        .PTR_BITS  (FIFO_PTR_BITS)
    ) u_black (
        .i_aclk     (i_aclk),
        .i_aresetn  (i_aresetn),
        .i_aclken   (i_aclken),
        .i_wr_valid (r_blk_wr_valid),
        .i_wr_data  (r_wr_data),
        .i_wr_user  (r_wr_user),
        .i_wr_last  (r_wr_last),
        .o_tdata    (o_black_tdata),
        .o_tuser    (o_black_tuser),
        .o_tlast    (o_black_tlast),
        .o_tvalid   (o_black_tvalid),
        .i_tready   (i_black_tready),
        .o_overflow (w_ovf_blk)
    );

    rtcl_p3s7_hs_dphy_line_parser_stream #(
        .DATA_BITS (PIX_BITS),
        .PTR_BITS  (FIFO_PTR_BITS)
    ) u_image (
        .i_aclk     (i_aclk),
        .i_aresetn  (i_aresetn),
        .i_aclken   (i_aclken),
        .i_wr_valid (r_img_wr_valid),
        .i_wr_data  (r_wr_data),
        .i_wr_user  (r_wr_user),
        .i_wr_last  (r_wr_last),
        .o_tdata    (o_image_tdata),
        .o_tuser    (o_image_tuser),
        .o_tlast    (o_image_tlast),
        .o_tvalid   (o_image_tvalid),
        .i_tready   (i_image_tready),
        .o_overflow (w_ovf_img)
    );

    assign o_header_data  = r_header_data;
    assign o_header_valid = r_header_valid;
    assign o_frame_count  = r_frame_count;
    assign o_err_short    = r_err_short;
    assign o_err_overflow = r_err_overflow;
endmodule

// File: tb/tb_rtcl_p3s7_hs_dphy_line_parser.sv
// Scoreboard bench: stimulus tasks push expected beats, per-stream monitors
// pop and compare whenever a beat is transferred.
module tb_rtcl_p3s7_hs_dphy_line_parser;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit toggle = 1'b0;

    // DUT A: 2 lanes, 1 pixel/beat, 4-beat buffers
    logic        a_aclken, a_dphy_valid, a_clear;
    logic [15:0] a_dphy_data;
    logic [9:0]  a_bw, a_iw, a_bh, a_ih;
    logic [9:0]  a_blk_tdata, a_img_tdata;
    logic        a_blk_tuser, a_blk_tlast, a_blk_tvalid, a_blk_tready;
    logic        a_img_tuser, a_img_tlast, a_img_tvalid, a_img_tready;
    logic [15:0] a_hdr_data, a_fcnt;
    logic        a_hdr_valid, a_err_short, a_err_ovf;

    // DUT B: 4 lanes, 2 pixels/beat
    logic        b_aclken, b_dphy_valid, b_clear;
    logic [31:0] b_dphy_data;
    logic [19:0] b_blk_tdata, b_img_tdata;
    logic        b_blk_tuser, b_blk_tlast, b_blk_tvalid;
    logic        b_img_tuser, b_img_tlast, b_img_tvalid;
    logic [31:0] b_hdr_data;
    logic [15:0] b_fcnt;
    logic        b_hdr_valid, b_err_short, b_err_ovf;

    logic [11:0] q_blk[$];
    logic [11:0] q_img[$];
    logic [21:0] q_b_img[$];

    rtcl_p3s7_hs_dphy_line_parser #(.DPHY_LANES(2), .CHANNELS(1), .FIFO_PTR_BITS(2)) u_dut_a (
        .i_aresetn(rst_n), .i_aclk(clk), .i_aclken(a_aclken),
        .i_param_black_width(a_bw), .i_param_black_height(a_bh),
        .i_param_image_width(a_iw), .i_param_image_height(a_ih),
        .i_dphy_data(a_dphy_data), .i_dphy_valid(a_dphy_valid),
        .o_black_tdata(a_blk_tdata), .o_black_tuser(a_blk_tuser), .o_black_tlast(a_blk_tlast),
        .o_black_tvalid(a_blk_tvalid), .i_black_tready(a_blk_tready),
        .o_image_tdata(a_img_tdata), .o_image_tuser(a_img_tuser), .o_image_tlast(a_img_tlast),
        .o_image_tvalid(a_img_tvalid), .i_image_tready(a_img_tready),
        .o_header_data(a_hdr_data), .o_header_valid(a_hdr_valid), .o_frame_count(a_fcnt),
        .i_clear_err(a_clear), .o_err_short(a_err_short), .o_err_overflow(a_err_ovf)
    );

    rtcl_p3s7_hs_dphy_line_parser #(.DPHY_LANES(4), .CHANNELS(2), .FIFO_PTR_BITS(6)) u_dut_b (
        .i_aresetn(rst_n), .i_aclk(clk), .i_aclken(b_aclken),
        .i_param_black_width(10'd2), .i_param_black_height(10'd1),
        .i_param_image_width(10'd4), .i_param_image_height(10'd1),
        .i_dphy_data(b_dphy_data), .i_dphy_valid(b_dphy_valid),
        .o_black_tdata(b_blk_tdata), .o_black_tuser(b_blk_tuser), .o_black_tlast(b_blk_tlast),
        .o_black_tvalid(b_blk_tvalid), .i_black_tready(1'b1),
        .o_image_tdata(b_img_tdata), .o_image_tuser(b_img_tuser), .o_image_tlast(b_img_tlast),
        .o_image_tvalid(b_img_tvalid), .i_image_tready(1'b1),
        .o_header_data(b_hdr_data), .o_header_valid(b_hdr_valid), .o_frame_count(b_fcnt),
        .i_clear_err(b_clear), .o_err_short(b_err_short), .o_err_overflow(b_err_ovf)
    );

    // Monitors: one line per transferred beat.
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n && a_aclken && a_img_tvalid && a_img_tready) begin
            n_vec++;
            if (q_img.size() == 0) begin
                n_err++;
                $display("FAIL img_beat unexpected got user=%0b last=%0b data=%h required none",
                         a_img_tuser, a_img_tlast, a_img_tdata);
            end else begin
                e = q_img.pop_front();
                if ({a_img_tuser, a_img_tlast, a_img_tdata} !== e) begin
                    n_err++;
                    $display("FAIL img_beat got user=%0b last=%0b data=%h required user=%0b last=%0b data=%h",
                             a_img_tuser, a_img_tlast, a_img_tdata, e[11], e[10], e[9:0]);
                end else
                    $display("img beat user=%0b last=%0b data=%h ok", e[11], e[10], e[9:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n && a_aclken && a_blk_tvalid && a_blk_tready) begin
            n_vec++;
            if (q_blk.size() == 0) begin
                n_err++;
                $display("FAIL blk_beat unexpected got user=%0b last=%0b data=%h required none",
                         a_blk_tuser, a_blk_tlast, a_blk_tdata);
            end else begin
                e = q_blk.pop_front();
                if ({a_blk_tuser, a_blk_tlast, a_blk_tdata} !== e) begin
                    n_err++;
                    $display("FAIL blk_beat got user=%0b last=%0b data=%h required user=%0b last=%0b data=%h",
                             a_blk_tuser, a_blk_tlast, a_blk_tdata, e[11], e[10], e[9:0]);
                end else
                    $display("blk beat user=%0b last=%0b data=%h ok", e[11], e[10], e[9:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [21:0] e;
        if (rst_n && b_aclken && b_img_tvalid) begin
            n_vec++;
            if (q_b_img.size() == 0) begin
                n_err++;
                $display("FAIL b_img_beat unexpected got data=%h required none", b_img_tdata);
            end else begin
                e = q_b_img.pop_front();
                if ({b_img_tuser, b_img_tlast, b_img_tdata} !== e) begin
                    n_err++;
                    $display("FAIL b_img_beat got user=%0b last=%0b data=%h required user=%0b last=%0b data=%h",
                             b_img_tuser, b_img_tlast, b_img_tdata, e[21], e[20], e[19:0]);
                end else
                    $display("b img beat data=%h ok", e[19:0]);
            end
        end
        if (rst_n && b_aclken && b_blk_tvalid) begin
            n_vec++;
            n_err++;
            $display("FAIL b_blk_beat unexpected got data=%h required none", b_blk_tdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end else
            $display("check %s = %0h ok", name, act);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [15:0] d, input logic v);
        if (toggle) begin
            a_aclken     = 1'b0;
            a_dphy_data  = 16'($urandom);
            a_dphy_valid = 1'($urandom);
            cyc();
        end
        a_aclken     = 1'b1;
        a_dphy_data  = d;
        a_dphy_valid = v;
        cyc();
    endtask

    task automatic idle(input int n);
        a_aclken     = 1'b1;
        a_dphy_valid = 1'b0;
        a_dphy_data  = '0;
        repeat (n) cyc();
    endtask

    // Push n expected beats: data base+i, tuser on beat 0 if user_first, tlast on beat last_at.
    task automatic exp_line(input bit blk, input int n, input int base, input bit user_first, input int last_at);
        for (int i = 0; i < n; i++) begin
            logic [11:0] e;
            e = {user_first && (i == 0), i == last_at, 10'(base + i)};
            if (blk) q_blk.push_back(e);
            else     q_img.push_back(e);
        end
    endtask

    task automatic burst(input logic [15:0] hdr, input int n, input int base);
        word(hdr, 1'b1);
        chk("header_valid", 32'(a_hdr_valid), 32'd1);
        chk("header_data", 32'(a_hdr_data), 32'(hdr));
        for (int i = 0; i < n; i++) word(16'(base + i), 1'b1);
        word(16'h0, 1'b0);
    endtask

    task automatic wait_drain();
        int i;
        idle(1);
        for (i = 0; i < 300 && (q_img.size() + q_blk.size() + q_b_img.size()) != 0; i++) cyc();
        chk("drain_pending", 32'(q_img.size() + q_blk.size() + q_b_img.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; a_aclken = 1'b1; a_dphy_valid = 1'b0; a_dphy_data = '0; a_clear = 1'b0;
        a_bw = 10'd8; a_bh = 10'd1; a_iw = 10'd8; a_ih = 10'd2;
        a_blk_tready = 1'b1; a_img_tready = 1'b1;
        b_aclken = 1'b1; b_dphy_valid = 1'b0; b_dphy_data = '0; b_clear = 1'b0;
        repeat (3) cyc();
        chk("rst_img_tvalid", 32'(a_img_tvalid), 32'd0);
        chk("rst_blk_tvalid", 32'(a_blk_tvalid), 32'd0);
        chk("rst_header_valid", 32'(a_hdr_valid), 32'd0);
        chk("rst_header_data", 32'(a_hdr_data), 32'd0);
        chk("rst_frame_count", 32'(a_fcnt), 32'd0);
        chk("rst_err", 32'({a_err_short, a_err_ovf}), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Two image lines; first line also checks the 2-cycle latency.
        exp_line(0, 8, 1, 1, 7);
        word(16'h0001, 1'b1);
        word(16'd1, 1'b1);
        chk("lat_n1_tvalid", 32'(a_img_tvalid), 32'd0);
        word(16'd2, 1'b1);
        chk("lat_n2_tvalid", 32'(a_img_tvalid), 32'd1);
        chk("lat_n2_tdata", 32'(a_img_tdata), 32'd1);
        for (int i = 3; i <= 8; i++) word(16'(i), 1'b1);
        word(16'h0, 1'b0);
        exp_line(0, 8, 9, 0, 7);
        burst(16'h0000, 8, 9);
        wait_drain();
        chk("t1_frame_count", 32'(a_fcnt), 32'd1);
        chk("t1_err", 32'({a_err_short, a_err_ovf}), 32'd0);

        // Black line, image line, then a black line past the black height.
        exp_line(1, 8, 'h100, 1, 7);
        burst(16'h0003, 8, 'h100);
        exp_line(0, 8, 'h200, 1, 7);
        burst(16'h0000, 8, 'h200);
        burst(16'h0002, 8, 'h300);
        wait_drain();
        chk("t2_frame_count", 32'(a_fcnt), 32'd2);

        // Short burst, clean recovery, clear, and clear beating a new error.
        exp_line(0, 5, 'h40, 1, -1);
        burst(16'h0001, 5, 'h40);
        chk("t3_err_short_set", 32'(a_err_short), 32'd1);
        exp_line(0, 8, 'h50, 1, 7);
        burst(16'h0001, 8, 'h50);
        wait_drain();
        chk("t3_err_short_sticky", 32'(a_err_short), 32'd1);
        a_clear = 1'b1; cyc(); a_clear = 1'b0;
        chk("t3_err_short_clr", 32'(a_err_short), 32'd0);
        exp_line(0, 2, 'h60, 1, -1);
        word(16'h0001, 1'b1); word(16'h60, 1'b1); word(16'h61, 1'b1);
        a_clear = 1'b1; word(16'h0, 1'b0); a_clear = 1'b0;
        chk("t3_clear_priority", 32'(a_err_short), 32'd0);
        wait_drain();
        chk("t3_frame_count", 32'(a_fcnt), 32'd5);

        // Stalled image stream with a 12-pixel line into a 4-beat buffer.
        a_iw = 10'd12; a_img_tready = 1'b0;
        exp_line(0, 4, 1, 1, -1);
        burst(16'h0001, 12, 1);
        idle(2);
        chk("t4_err_overflow", 32'(a_err_ovf), 32'd1);
        chk("t4_stall_tvalid", 32'(a_img_tvalid), 32'd1);
        chk("t4_stall_tdata", 32'({a_img_tuser, a_img_tdata}), 32'({1'b1, 10'd1}));
        exp_line(1, 8, 'h120, 1, 7);
        burst(16'h0002, 8, 'h120);
        idle(12);
        chk("t4_black_done", 32'(q_blk.size()), 32'd0);
        a_img_tready = 1'b1;
        wait_drain();
        a_clear = 1'b1; cyc(); a_clear = 1'b0;
        chk("t4_err_overflow_clr", 32'(a_err_ovf), 32'd0);
        a_iw = 10'd8;

        // Repeat of the first pair of lines with aclken toggling.
        toggle = 1'b1;
        exp_line(0, 8, 1, 1, 7);
        burst(16'h0001, 8, 1);
        exp_line(0, 8, 9, 0, 7);
        burst(16'h0000, 8, 9);
        toggle = 1'b0;
        wait_drain();
        chk("t5_frame_count", 32'(a_fcnt), 32'd7);
        chk("t5_err", 32'({a_err_short, a_err_ovf}), 32'd0);

        // Reset in the middle of a line (stalled so no beats are consumed).
        a_img_tready = 1'b0;
        word(16'h0001, 1'b1); word(16'd1, 1'b1); word(16'd2, 1'b1); word(16'd3, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_img_tvalid", 32'(a_img_tvalid), 32'd0);
        chk("mid_rst_frame_count", 32'(a_fcnt), 32'd0);
        chk("mid_rst_header_data", 32'(a_hdr_data), 32'd0);
        chk("mid_rst_header_valid", 32'(a_hdr_valid), 32'd0);
        idle(2);
        rst_n = 1'b1; a_img_tready = 1'b1;
        idle(2);

        // 254 frame starts routed to SKIP, then pixel masking.
        a_bh = 10'd0;
        for (int i = 0; i < 254; i++) begin
            word(16'h0003, 1'b1);
            word(16'h0, 1'b0);
        end
        chk("t6_frame_count_254", 32'(a_fcnt), 32'd254);
        chk("t6_no_err", 32'({a_err_short, a_err_ovf}), 32'd0);
        a_bh = 10'd1;
        for (int i = 0; i < 8; i++)
            q_img.push_back({i == 0, i == 7, (i % 2 == 1) ? 10'h3FF : 10'h001});
        word(16'h0001, 1'b1);
        for (int i = 0; i < 8; i++) word((i % 2 == 1) ? 16'hFFFF : 16'hFC01, 1'b1);
        word(16'h0, 1'b0);
        wait_drain();
        chk("t6_frame_count_255", 32'(a_fcnt), 32'd255);

        // Four lanes: two pixels per beat with upper bits masked.
        q_b_img.push_back({1'b1, 1'b0, 10'h3CD, 10'h001});
        q_b_img.push_back({1'b0, 1'b1, 10'h001, 10'h001});
        b_dphy_data = 32'h0000_0001; b_dphy_valid = 1'b1; cyc();
        chk("b_header_valid", 32'(b_hdr_valid), 32'd1);
        b_dphy_data = {16'h0BCD, 16'hFC01}; cyc();
        b_dphy_data = {16'hFC01, 16'hFC01}; cyc();
        b_dphy_data = '0; b_dphy_valid = 1'b0; cyc();
        wait_drain();
        chk("b_frame_count", 32'(b_fcnt), 32'd1);
        chk("b_err", 32'({b_err_short, b_err_ovf}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
